// File: rtl/dg_data_gen.sv
// dg_data_gen: stimulus source emitting NUM_WORDS words of an arithmetic
// sequence on an ap_hs (vld/ack) stream, under HLS-style block control.
// Runs restart automatically while ap_start stays high.
module dg_data_gen #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter logic [31:0] STEP      = 32'h0000_0001
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [31:0] Output_1_V_V,
    output logic        Output_1_V_V_ap_vld,
    input  logic        Output_1_V_V_ap_ack
);

    // Index of the last word of a run; NUM_WORDS up to 2^16 keeps this in 16 bits.
    localparam logic [15:0] LastK = 16'(NUM_WORDS - 32'd1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] k_q, k_d;
    logic [31:0] data_q, data_d;
    logic        xfer;
    logic        last;

    // A word is transferred when the current word is valid and accepted.
    assign xfer = (state_q == StRun) && Output_1_V_V_ap_ack;
    assign last = (k_q == LastK);

    // State register with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ap_start is only looked at in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ap_start) state_d = StRun;
            end
            StRun: begin
                if (xfer && last) state_d = StDone;
            end
            StDone: begin
                state_d = ap_start ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Word index and data next-state: load BASE on entering RUN, advance on each transfer.
    always_comb begin
        k_d    = k_q;
        data_d = data_q;
        unique case (state_q)
            StIdle, StDone: begin
                k_d = '0;
                if (ap_start) data_d = BASE;
            end
            StRun: begin
                if (xfer) begin
                    if (last) begin
                        k_d = '0;
                    end else begin
                        k_d    = k_q + 16'd1;
                        data_d = data_q + STEP;
                    end
                end
            end
            default: begin
                k_d = '0;
            end
        endcase
    end

    // Datapath registers; data is registered so ack never reaches it combinationally.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            k_q    <= '0;
            data_q <= '0;
        end else begin
            k_q    <= k_d;
            data_q <= data_d;
        end
    end

    // Block-control and stream-valid outputs decoded from the state register.
    always_comb begin
        ap_idle             = 1'b0;
        ap_done             = 1'b0;
        ap_ready            = 1'b0;
        Output_1_V_V_ap_vld = 1'b0;
        unique case (state_q)
            StIdle: ap_idle = 1'b1;
            StRun:  Output_1_V_V_ap_vld = 1'b1;
            StDone: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ap_idle = 1'b1;
        endcase
    end

    assign Output_1_V_V = data_q;

endmodule

// File: tb/tb_dg_data_gen.sv
// Directed bench for dg_data_gen: three instances share stimulus
// (4-word base 0, 4-word wrapping base, single-word run).
module tb_dg_data_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ack;

    logic        done_a, idle_a, ready_a, vld_a;
    logic [31:0] data_a;
    logic        done_w, idle_w, ready_w, vld_w;
    logic [31:0] data_w;
    logic        done_o, idle_o, ready_o, vld_o;
    logic [31:0] data_o;

    int checks   = 0;
    int failures = 0;

    dg_data_gen #(.NUM_WORDS(4), .BASE(32'h0000_0000), .STEP(32'h1)) u_dut (
        .ap_clk              (clk),
        .ap_rst              (rst),
        .ap_start            (start),
        .ap_done             (done_a),
        .ap_idle             (idle_a),
        .ap_ready            (ready_a),
        .Output_1_V_V        (data_a),
        .Output_1_V_V_ap_vld (vld_a),
        .Output_1_V_V_ap_ack (ack)
    );

    dg_data_gen #(.NUM_WORDS(4), .BASE(32'hFFFF_FFFE), .STEP(32'h1)) u_wrap (
        .ap_clk              (clk),
        .ap_rst              (rst),
        .ap_start            (start),
        .ap_done             (done_w),
        .ap_idle             (idle_w),
        .ap_ready            (ready_w),
        .Output_1_V_V        (data_w),
        .Output_1_V_V_ap_vld (vld_w),
        .Output_1_V_V_ap_ack (ack)
    );

    dg_data_gen #(.NUM_WORDS(1), .BASE(32'd5), .STEP(32'd7)) u_one (
        .ap_clk              (clk),
        .ap_rst              (rst),
        .ap_start            (start),
        .ap_done             (done_o),
        .ap_idle             (idle_o),
        .ap_ready            (ready_o),
        .Output_1_V_V        (data_o),
        .Output_1_V_V_ap_vld (vld_o),
        .Output_1_V_V_ap_ack (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rcv;
        logic [3:0] pat;
        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;

        // 1. Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_vld",  32'(vld_a),  32'd0);
            check("rst_idle", 32'(idle_a), 32'd1);
            check("rst_done", 32'(done_a), 32'd0);
            check("rst_data", data_a,      32'd0);
        end
        rst = 1'b0;
        tick();
        check("idle_after_rst", 32'(idle_a), 32'd1);
        check("vld_after_rst",  32'(vld_a),  32'd0);

        // 2. One-cycle start pulse, ack high; also covers wrap and single-word instances.
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("run_vld",  32'(vld_a),  32'd1);
            check("run_data", data_a,      32'(i));
            check("run_idle", 32'(idle_a), 32'd0);
            check("run_done", 32'(done_a), 32'd0);
            check("wrap_data", data_w, 32'hFFFF_FFFE + 32'(i));
            check("wrap_vld",  32'(vld_w), 32'd1);
            if (i == 0) begin
                check("one_vld",  32'(vld_o), 32'd1);
                check("one_data", data_o,     32'd5);
            end
            if (i == 1) begin
                check("one_done", 32'(done_o), 32'd1);
                check("one_vld0", 32'(vld_o),  32'd0);
            end
            if (i == 2) check("one_idle", 32'(idle_o), 32'd1);
            tick();
        end
        check("done_pulse",  32'(done_a),  32'd1);
        check("ready_pulse", 32'(ready_a), 32'd1);
        check("done_vld",    32'(vld_a),   32'd0);
        check("done_idle",   32'(idle_a),  32'd0);
        check("wrap_done",   32'(done_w),  32'd1);
        tick();
        check("post_idle",  32'(idle_a),  32'd1);
        check("post_done",  32'(done_a),  32'd0);
        check("post_ready", 32'(ready_a), 32'd0);

        // 3. Backpressure with ack pattern 1,0,0,1 repeating.
        pat   = 4'b1001;
        start = 1'b1;
        tick();
        start = 1'b0;
        rcv   = 0;
        for (int c = 0; c < 40 && rcv < 4; c++) begin
            ack = pat[c % 4];
            check("bp_vld",  32'(vld_a), 32'd1);
            check("bp_data", data_a,     32'(rcv));
            if (ack) rcv++;
            tick();
        end
        check("bp_count", 32'(rcv),    32'd4);
        check("bp_done",  32'(done_a), 32'd1);
        ack = 1'b1;
        tick();
        check("bp_idle", 32'(idle_a), 32'd1);

        // 4. Start held high: back-to-back runs, then drop start mid-run.
        start = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            if (r == 3) start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("auto_vld",  32'(vld_a),  32'd1);
                check("auto_data", data_a,      32'(i));
                check("auto_idle", 32'(idle_a), 32'd0);
                tick();
            end
            check("auto_gap_vld",  32'(vld_a),  32'd0);
            check("auto_gap_done", 32'(done_a), 32'd1);
            check("auto_gap_idle", 32'(idle_a), 32'd0);
            tick();
        end
        check("auto_end_idle", 32'(idle_a), 32'd1);

        // 6. Reset while word 2 is presented.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_w0", data_a, 32'd0);
        tick();
        check("ab_w1", data_a, 32'd1);
        tick();
        check("ab_w2", data_a, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ab_vld",  32'(vld_a),  32'd0);
        check("ab_idle", 32'(idle_a), 32'd1);
        check("ab_data", data_a,      32'd0);
        for (int i = 0; i < 3; i++) begin
            check("ab_nodone", 32'(done_a), 32'd0);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_vld",  32'(vld_a), 32'd1);
        check("restart_data", data_a,     32'd0);
        tick();
        check("restart_next", data_a, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
